param_collect2: RTL and testbench
=================================

PARAM_COLLECT2 -- requirements
Module: param_collect2

Interface
REQ-001 Parameter N_KERN, default 4: number of layer-2 kernels.
REQ-002 Parameter N_TAP, default 18: 16-bit taps per kernel (2 input maps x 3x3).
REQ-003 Parameter W, default 16: weight/bias word width.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rst  in  1  synchronous reset, active-low (rst=0 resets on the clk edge).
REQ-006 in_valid  in  1  one beat of filt2/bias2 is present this cycle.
REQ-007 filt2  in  48  three taps; tap j occupies bits [16j+15:16j], j=0..2.
REQ-008 bias2  in  16  bias of the kernel the beat belongs to.
REQ-009 rd_en  in  1  read request.
REQ-010 rd_kernel  in  2  kernel select 0..3.
REQ-011 rd_tap  in  5  tap select 0..17.
REQ-012 rd_weight  out  16  registered read weight.
REQ-013 rd_bias  out  16  registered bias of rd_kernel.
REQ-014 rd_valid  out  1  rd_weight/rd_bias valid this cycle.
REQ-015 load_done  out  1  a full 24-beat set is stored.
REQ-016 busy  out  1  load in progress.
REQ-017 err_bias  out  1  sticky: bias2 differed across beats of one kernel.

Function
REQ-018 The block is the receiving end of the layer-2 parameter stream and deinterleaves 24 beats into N_KERN x N_TAP weights plus N_KERN biases.
REQ-019 Beat index b (0..23) maps to: half h=b/12, kernel k=(b mod 12)/3, row r=b mod 3; filt2 tap j is stored at kernel k, tap 9h+3r+j.
REQ-020 FSM states: IDLE, LOAD, DONE; reset enters IDLE.
REQ-021 IDLE: in_valid=1 stores beat 0, b<=1, enters LOAD; busy=1 from next cycle.
REQ-022 LOAD: each in_valid=1 cycle stores beat b and increments b; in_valid=0 holds b (gaps of any length allowed).
REQ-023 LOAD: storing beat 23 enters DONE; load_done=1 and busy=0 from the next cycle.
REQ-024 DONE: in_valid=1 starts a new load as beat 0 and clears load_done in the same edge; storage is overwritten beat by beat.
REQ-025 Bias is captured on beats with h=0, r=0; on every other beat of the kernel, bias2 not equal to the captured value sets err_bias; err_bias is cleared only by reset or by the start of a new load.
REQ-026 Read: rd_en=1 with load_done=1 gives rd_valid=1 and data on the next cycle (1-cycle latency); rd_valid=0 otherwise.
REQ-027 rd_tap>17 returns rd_weight=0 with rd_valid=1; rd_bias is still returned.
REQ-028 A read in the same cycle as a reload's beat 0 returns the pre-reload contents, because load_done was 1 at the sampling edge.
REQ-029 rd_weight/rd_bias hold their last value while rd_valid=0.

Reset
REQ-030 On rst=0 at a clock edge: state=IDLE, b=0, load_done=0, busy=0, err_bias=0, rd_valid=0, rd_weight=0, rd_bias=0, and all stored weights/biases are set to 0.
REQ-031 Reset during LOAD abandons the partial set; the next in_valid is treated as beat 0.

Structure
REQ-032 A shared CNN parameter package holds N_KERN, N_TAP, W, the beat count 24, and the FSM state encoding.
REQ-033 The tap-address decode (b -> k, base tap) is one sub-module, param_beat_decode, and is purely combinational.

Verification
REQ-034 Stream the layer-2 set with no gaps (beat 0 = {0x18,0x36,0x6}, bias 0x36), then read k=0 tap 0 -> rd_weight=0x0006, rd_bias=0x0036, rd_valid=1 one cycle after rd_en.
REQ-035 Same load, read k=0 tap 9 -> 0x0036, k=0 tap 11 -> 0x0048, k=3 tap 17 -> 0x0004; load_done=1 exactly one cycle after beat 23.
REQ-036 Insert 5-cycle in_valid gaps after beats 3 and 14 -> identical read-back to REQ-034/035; busy=1 throughout the gaps.
REQ-037 Beat 4 (k=1, r=1) with bias2=0x37 -> err_bias=1 and stays 1 after load_done; a new load start clears it.
REQ-038 rst=0 asserted after beat 10 -> load_done=0 and all reads give rd_valid=0; a full restream then reads correctly.
REQ-039 rd_en with rd_tap=20 -> rd_weight=0, rd_valid=1; rd_en before load_done -> rd_valid=0.

Source files
------------

// File: rtl/param_collect2_pkg.sv
// Shared CNN layer-2 parameter definitions: sizes, beat count and FSM encoding.
package param_collect2_pkg;

   localparam int CNN_N_KERN     = 4;
   localparam int CNN_N_TAP      = 18;
   localparam int CNN_W          = 16;
   localparam int N_BEAT         = 24;
   localparam int BEATS_PER_HALF = 12;
   localparam int TAPS_PER_BEAT  = 3;
   localparam int BEAT_W         = 5;
   localparam int KERN_W         = 2;
   localparam int TAP_W          = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/param_collect2_beat_decode.sv
// Beat index -> kernel, first tap of the beat's row, and whether it carries the bias.
module param_beat_decode
   import param_collect2_pkg::*;
(
   input  logic [BEAT_W-1:0] beat,
   output logic [KERN_W-1:0] kern,
   output logic [TAP_W-1:0]  base_tap,
   output logic              bias_beat
);

   logic              half;
   logic [BEAT_W-1:0] pos;
   logic [1:0]        row;

   // Split the beat into half (input map), kernel and row within the 3x3 window.
   always_comb begin
      half      = (beat >= BEAT_W'(BEATS_PER_HALF));
      pos       = half ? (beat - BEAT_W'(BEATS_PER_HALF)) : beat;
      kern      = KERN_W'(pos / BEAT_W'(3));
      row       = 2'(pos % BEAT_W'(3));
      base_tap  = (half ? TAP_W'(9) : TAP_W'(0)) + (TAP_W'(3) * TAP_W'(row));
      bias_beat = !half && (row == 2'd0);
   end

endmodule

// File: rtl/param_collect2.sv
// Layer-2 parameter receiver: deinterleaves the 24-beat stream into weights and
// biases, flags bias inconsistency, and serves registered single-word reads.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | nothing loaded since reset; first in_valid is beat 0
//   LOAD    | beats 1..23 being collected; beat counter holds across gaps
//   DONE    | full set stored, reads allowed; in_valid restarts as beat 0
module param_collect2
   import param_collect2_pkg::*;
#(
   parameter int N_KERN = CNN_N_KERN,
   parameter int N_TAP  = CNN_N_TAP,
   parameter int W      = CNN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [3*W-1:0]    filt2,
   input  logic [W-1:0]      bias2,
   input  logic              rd_en,
   input  logic [KERN_W-1:0] rd_kernel,
   input  logic [TAP_W-1:0]  rd_tap,
   output logic [W-1:0]      rd_weight,
   output logic [W-1:0]      rd_bias,
   output logic              rd_valid,
   output logic              load_done,
   output logic              busy,
   output logic              err_bias
);

   state_t            state;
   logic [BEAT_W-1:0] beat;
   logic [W-1:0]      wt_mem   [N_KERN][N_TAP];
   logic [W-1:0]      bias_mem [N_KERN];

   logic [KERN_W-1:0] dec_kern;
   logic [TAP_W-1:0]  dec_tap;
   logic              dec_bias_beat;
   logic              bias_mismatch;
   logic              tap_ok;
   logic [TAP_W-1:0]  tap_idx;

   // beat is 0 outside LOAD, so IDLE/DONE arrivals decode as beat 0.
   param_beat_decode u_decode (
      .beat      (beat),
      .kern      (dec_kern),
      .base_tap  (dec_tap),
      .bias_beat (dec_bias_beat)
   );

   // Non-capture beats are compared with the bias captured earlier in this load.
   always_comb begin
      bias_mismatch = in_valid && !dec_bias_beat && (bias2 != bias_mem[dec_kern]);
      tap_ok        = (rd_tap < TAP_W'(N_TAP));
      tap_idx       = tap_ok ? rd_tap : '0;
   end

   // Load sequencing, status flags and sticky bias error.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         beat      <= '0;
         load_done <= 1'b0;
         busy      <= 1'b0;
         err_bias  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (in_valid) begin
                  state     <= ST_LOAD;
                  beat      <= BEAT_W'(1);
                  busy      <= 1'b1;
                  load_done <= 1'b0;
                  err_bias  <= 1'b0;
               end
            end
            ST_LOAD: begin
               if (in_valid) begin
                  if (bias_mismatch) err_bias <= 1'b1;
                  if (beat == BEAT_W'(N_BEAT - 1)) begin
                     state     <= ST_DONE;
                     beat      <= '0;
                     busy      <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     beat <= beat + BEAT_W'(1);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Weight/bias storage, overwritten beat by beat on every accepted beat.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int k = 0; k < N_KERN; k++) begin
            bias_mem[k] <= '0;
            for (int t = 0; t < N_TAP; t++) wt_mem[k][t] <= '0;
         end
      end else if (in_valid) begin
         for (int j = 0; j < TAPS_PER_BEAT; j++)
            wt_mem[dec_kern][dec_tap + TAP_W'(j)] <= filt2[W*j +: W];
         if (dec_bias_beat) bias_mem[dec_kern] <= bias2;
      end
   end

   // Registered read port; data holds while no valid read is issued.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_valid  <= 1'b0;
         rd_weight <= '0;
         rd_bias   <= '0;
      end else if (rd_en && load_done) begin
         rd_valid  <= 1'b1;
         rd_weight <= tap_ok ? wt_mem[rd_kernel][tap_idx] : '0;
         rd_bias   <= bias_mem[rd_kernel];
      end else begin
         rd_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_param_collect2.sv
// Self-checking bench for param_collect2 with a read scoreboard.
module tb_param_collect2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [47:0] filt2 = '0;
   logic [15:0] bias2 = '0;
   logic        rd_en = 1'b0;
   logic [1:0]  rd_kernel = '0;
   logic [4:0]  rd_tap = '0;
   logic [15:0] rd_weight, rd_bias;
   logic        rd_valid, load_done, busy, err_bias;

   param_collect2 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .filt2     (filt2),
      .bias2     (bias2),
      .rd_en     (rd_en),
      .rd_kernel (rd_kernel),
      .rd_tap    (rd_tap),
      .rd_weight (rd_weight),
      .rd_bias   (rd_bias),
      .rd_valid  (rd_valid),
      .load_done (load_done),
      .busy      (busy),
      .err_bias  (err_bias)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        v;
      logic [15:0] w;
      logic [15:0] b;
   } rd_exp_t;

   rd_exp_t     sb[$];
   logic [15:0] exp_w[4][18];
   logic [15:0] exp_b[4];
   logic [15:0] src_w[4][18];
   logic [15:0] src_b[4];
   logic        exp_done = 1'b0;
   logic        exp_err  = 1'b0;
   logic [15:0] last_w = '0;
   logic [15:0] last_b = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Source parameter set; seed 0 carries the reference values.
   function automatic void build_src(input int seed);
      for (int k = 0; k < 4; k++) begin
         src_b[k] = 16'(16'h0036 + k * 16'h0011 + seed * 16'h0100);
         for (int t = 0; t < 18; t++)
            src_w[k][t] = 16'(seed * 16'h1000 + k * 16'h0040 + t * 3 + 1);
      end
      if (seed == 0) begin
         src_w[0][0]  = 16'h0006;
         src_w[0][1]  = 16'h0036;
         src_w[0][2]  = 16'h0018;
         src_w[0][9]  = 16'h0036;
         src_w[0][11] = 16'h0048;
         src_w[3][17] = 16'h0004;
      end
   endfunction

   task automatic drive_read(input bit en, input int k, input int t);
      rd_exp_t e;
      rd_en     = en;
      rd_kernel = 2'(k);
      rd_tap    = 5'(t);
      if (en && exp_done) begin
         e.v = 1'b1;
         e.w = (t < 18) ? exp_w[k][t] : 16'h0000;
         e.b = exp_b[k];
         last_w = e.w;
         last_b = e.b;
      end else begin
         e.v = 1'b0;
         e.w = last_w;
         e.b = last_b;
      end
      sb.push_back(e);
   endtask

   task automatic compare_read(input string tag);
      rd_exp_t e;
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check({tag, "_valid"}, 32'(rd_valid), 32'(e.v));
         check({tag, "_weight"}, 32'(rd_weight), 32'(e.w));
         check({tag, "_bias"}, 32'(rd_bias), 32'(e.b));
      end
   endtask

   task automatic do_read(input bit en, input int k, input int t);
      @(negedge clk);
      drive_read(en, k, t);
      @(negedge clk);
      rd_en = 1'b0;
      compare_read($sformatf("rd_k%0dt%0d", k, t));
   endtask

   // Streams n beats of src_*; optional gaps after two beats; optional read on beat 0.
   task automatic stream(input int n, input int gap_a, input int gap_b, input int gap_len,
                         input bit bad_bias, input bit rd0);
      int h, k, r;
      for (int b = 0; b < n; b++) begin
         @(negedge clk);
         if (b == 1 && rd0) begin
            rd_en = 1'b0;
            compare_read("rd_reload_beat0");
         end
         h = b / 12;
         k = (b % 12) / 3;
         r = b % 3;
         for (int j = 0; j < 3; j++) filt2[16*j +: 16] = src_w[k][9*h + 3*r + j];
         bias2 = src_b[k];
         if (bad_bias && b == 4) begin
            bias2   = 16'h0037;
            exp_err = 1'b1;
         end
         in_valid = 1'b1;
         if (b == 0) begin
            if (rd0) drive_read(1'b1, 0, 0);
            exp_done = 1'b0;
            exp_err  = 1'b0;
         end
         if (b > 0) check($sformatf("busy_b%0d", b), 32'(busy), 32'd1);
         if (b == 23) check("done_at_b23", 32'(load_done), 32'd0);
         if ((b == gap_a || b == gap_b) && gap_len > 0) begin
            repeat (gap_len) begin
               @(negedge clk);
               in_valid = 1'b0;
               check($sformatf("busy_gap_b%0d", b), 32'(busy), 32'd1);
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (n == 24) begin
         check("load_done_b23p1", 32'(load_done), 32'd1);
         check("busy_after_done", 32'(busy), 32'd0);
         exp_done = 1'b1;
         exp_w    = src_w;
         exp_b    = src_b;
      end
      check("err_bias", 32'(err_bias), 32'(exp_err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b0;
      in_valid = 1'b0;
      rd_en    = 1'b0;
      @(negedge clk);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_bias), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_rd_weight", 32'(rd_weight), 32'd0);
      check("rst_rd_bias", 32'(rd_bias), 32'd0);
      rst      = 1'b1;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      last_w   = '0;
      last_b   = '0;
      for (int k = 0; k < 4; k++) begin
         exp_b[k] = '0;
         for (int t = 0; t < 18; t++) exp_w[k][t] = '0;
      end
      sb.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      do_reset();

      do_read(1'b1, 0, 0);

      build_src(0);
      stream(24, -1, -1, 0, 1'b0, 1'b0);
      do_read(1'b1, 0, 0);
      check("ref_k0t0_w", 32'(rd_weight), 32'h0006);
      check("ref_k0_b", 32'(rd_bias), 32'h0036);
      do_read(1'b1, 0, 9);
      check("ref_k0t9_w", 32'(rd_weight), 32'h0036);
      do_read(1'b1, 0, 11);
      check("ref_k0t11_w", 32'(rd_weight), 32'h0048);
      do_read(1'b1, 3, 17);
      check("ref_k3t17_w", 32'(rd_weight), 32'h0004);
      do_read(1'b1, 2, 5);
      do_read(1'b1, 1, 20);
      check("tap20_w", 32'(rd_weight), 32'h0000);
      do_read(1'b0, 0, 0);

      stream(24, 3, 14, 5, 1'b0, 1'b0);
      do_read(1'b1, 0, 0);
      check("gap_k0t0_w", 32'(rd_weight), 32'h0006);
      do_read(1'b1, 0, 11);
      check("gap_k0t11_w", 32'(rd_weight), 32'h0048);
      do_read(1'b1, 3, 17);
      check("gap_k3t17_w", 32'(rd_weight), 32'h0004);

      build_src(1);
      stream(24, -1, -1, 0, 1'b1, 1'b1);
      check("err_after_done", 32'(err_bias), 32'd1);
      do_read(1'b1, 1, 4);
      do_read(1'b1, 3, 12);

      build_src(2);
      stream(24, 7, -1, 2, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++)
         for (int t = 0; t < 18; t++) do_read(1'b1, k, t);

      build_src(3);
      stream(11, -1, -1, 0, 1'b0, 1'b0);
      do_read(1'b1, 0, 0);
      do_reset();
      do_read(1'b1, 0, 0);
      do_read(1'b1, 2, 7);
      build_src(0);
      stream(24, -1, -1, 0, 1'b0, 1'b0);
      do_read(1'b1, 0, 0);
      check("restream_k0t0_w", 32'(rd_weight), 32'h0006);
      do_read(1'b1, 0, 9);
      do_read(1'b1, 3, 17);
      do_read(1'b1, 1, 13);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
